// File: rtl/button_bank.sv
// -----------------------------------------------------------------------------
// button_bank
//   Multi-channel push-button conditioner. Each raw button level is passed
//   through a synchroniser, then debounced and edge-detected. A small press
//   tracker per channel produces a long-press pulse and, optionally, periodic
//   auto-repeat pulses while the button stays held.
//
// Optional feature macro: BUTTON_REPEAT_EN
//   defined   -> repeat counters and HELD-state auto-repeat are built in
//   undefined -> o_repeat is constant 0 and HELD simply waits for release
//
// Ports
//   i_clk          : single clock for all logic
//   i_reset        : synchronous, active-high reset
//   i_noisy        : raw asynchronous button levels, bit i = channel i
//   o_debounced    : registered clean level per channel
//   o_p_edge       : one-cycle pulse on a rising debounced level
//   o_n_edge       : one-cycle pulse on a falling debounced level
//   o_edge         : o_p_edge | o_n_edge
//   o_long_press   : one-cycle pulse when a press has lasted HOLD_CYCLES
//   o_repeat       : one-cycle auto-repeat pulses (0 without the macro)
// -----------------------------------------------------------------------------
module button_bank #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [CHANNELS-1:0] i_noisy,
    output logic [CHANNELS-1:0] o_debounced,
    output logic [CHANNELS-1:0] o_p_edge,
    output logic [CHANNELS-1:0] o_n_edge,
    output logic [CHANNELS-1:0] o_edge,
    output logic [CHANNELS-1:0] o_long_press,
    output logic [CHANNELS-1:0] o_repeat
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

`ifdef BUTTON_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
`else
    // REPEAT_CYCLES has no effect when auto-repeat is not built in.
    if (REPEAT_CYCLES < 1) begin : g_repeat_cycles_unused
    end
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [DB_W-1:0]        r_db_cnt;
        logic                   r_deb;
        logic                   r_deb_q;
        state_t                 r_state;
        state_t                 w_state_nxt;
        logic [HOLD_W-1:0]      r_hold;
        logic [HOLD_W-1:0]      w_hold_nxt;
        logic                   w_synced;
        logic                   w_p;
        logic                   w_n;
        logic                   w_long;
        logic                   w_rep;
`ifdef BUTTON_REPEAT_EN
        logic [REP_W-1:0]       r_rep;
        logic [REP_W-1:0]       w_rep_nxt;
`endif

        assign w_synced = r_sync[SYNC_STAGES-1];
        assign w_p      = r_deb & ~r_deb_q;
        assign w_n      = ~r_deb & r_deb_q;

        // Synchroniser, debouncer and edge-delay register.
        // The debounce counter toggles the clean level on the cycle it would
        // reach DEBOUNCE_CYCLES; any cycle of agreement restarts the count.
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_sync   <= '0;
                r_db_cnt <= '0;
                r_deb    <= 1'b0;
                r_deb_q  <= 1'b0;
            end else begin
                r_sync  <= {r_sync[SYNC_STAGES-2:0], i_noisy[g]};
                r_deb_q <= r_deb;
                if (w_synced != r_deb) begin
                    if (r_db_cnt == DB_LAST) begin
                        r_deb    <= ~r_deb;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end else begin
                    r_db_cnt <= '0;
                end
            end
        end

        // Press tracker state register.
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_state <= IDLE;
                r_hold  <= '0;
`ifdef BUTTON_REPEAT_EN
                r_rep   <= '0;
`endif
            end else begin
                r_state <= w_state_nxt;
                r_hold  <= w_hold_nxt;
`ifdef BUTTON_REPEAT_EN
                r_rep   <= w_rep_nxt;
`endif
            end
        end

        // Pulses fire on the cycle a counter would reach its target, so a
        // release (n_edge) seen in that same cycle suppresses the pulse.
        always_comb begin
            w_state_nxt = r_state;
            w_hold_nxt  = r_hold;
            w_long      = 1'b0;
            w_rep       = 1'b0;
`ifdef BUTTON_REPEAT_EN
            w_rep_nxt   = r_rep;
`endif
            case (r_state)
                IDLE: begin
                    if (w_p) begin
                        w_state_nxt = PRESSED;
                        w_hold_nxt  = '0;
                    end
                end
                PRESSED: begin
                    if (w_n) begin
                        w_state_nxt = IDLE;
                        w_hold_nxt  = '0;
                    end else begin
                        if (r_hold != HOLD_MAX) begin
                            w_hold_nxt = r_hold + 1'b1;
                        end
                        if (r_hold == HOLD_LAST) begin
                            w_long      = 1'b1;
                            w_state_nxt = HELD;
`ifdef BUTTON_REPEAT_EN
                            w_rep_nxt   = '0;
`endif
                        end
                    end
                end
                HELD: begin
                    if (w_n) begin
                        w_state_nxt = IDLE;
                        w_hold_nxt  = '0;
`ifdef BUTTON_REPEAT_EN
                        w_rep_nxt   = '0;
                    end else if (r_rep == REP_LAST) begin
                        w_rep     = 1'b1;
                        w_rep_nxt = '0;
                    end else begin
                        w_rep_nxt = r_rep + 1'b1;
`endif
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_hold_nxt  = '0;
                end
            endcase
        end

        assign o_debounced[g]  = r_deb;
        assign o_p_edge[g]     = w_p;
        assign o_n_edge[g]     = w_n;
        assign o_edge[g]       = w_p | w_n;
        assign o_long_press[g] = w_long;
        assign o_repeat[g]     = w_rep;
    end

endmodule

// File: tb/tb_button_bank.sv
module tb_button_bank;

    localparam int CH   = 2;
    localparam int S    = 2;
    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;
    localparam int HL   = S + DB;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] noisy;
    logic [CH-1:0] debounced, p_edge, n_edge, any_edge, long_press, rpt;

    always #5 clk = ~clk;

    button_bank #(
        .CHANNELS(CH), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_noisy(noisy),
        .o_debounced(debounced), .o_p_edge(p_edge), .o_n_edge(n_edge),
        .o_edge(any_edge), .o_long_press(long_press), .o_repeat(rpt)
    );

    int errors = 0;
    int checks = 0;
    int sn     = 0;

    // Reference model: the clean level flips once the synchronised level
    // (the raw sample S-1 edges earlier) disagreed with it for the last DB
    // cycles; press events are timed from the rising edge's cycle number.
    bit        hist [CH][HL];
    bit        m_deb [CH];
    bit        m_debq [CH];
    bit        m_act [CH];
    int        m_start [CH];
    int        cyc = 0;
    logic [CH-1:0] e_deb, e_pe, e_ne, e_lp, e_rp;

    // Event trackers for the hand-written sequences.
    int t_p [CH];
    int t_n [CH];
    int t_lp [CH];
    int n_pe [CH];
    int n_ne [CH];
    int n_lp [CH];
    int n_rp [CH];
    int late [CH];
    int rep1_t[$];

    typedef struct {
        logic [CH-1:0] noisy;
        logic          rst;
        logic [CH-1:0] deb;
        logic [CH-1:0] pe;
        logic [CH-1:0] ne;
        logic [CH-1:0] lp;
        logic [CH-1:0] rp;
    } vec_t;

    vec_t tbl [20];

    task automatic model_step(input logic [CH-1:0] v, input logic rst);
        int d;
        bit all_diff;
        cyc++;
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                for (int j = 0; j < HL; j++) hist[c][j] = 1'b0;
                m_deb[c] = 1'b0; m_debq[c] = 1'b0; m_act[c] = 1'b0;
                e_deb[c] = 1'b0; e_pe[c] = 1'b0; e_ne[c] = 1'b0;
                e_lp[c] = 1'b0; e_rp[c] = 1'b0;
            end else begin
                all_diff = 1'b1;
                for (int j = 1; j <= DB; j++)
                    if (hist[c][j] == m_deb[c]) all_diff = 1'b0;
                for (int j = 0; j < HL - 1; j++) hist[c][j] = hist[c][j+1];
                hist[c][HL-1] = v[c];
                m_debq[c] = m_deb[c];
                if (all_diff) m_deb[c] = ~m_deb[c];
                e_deb[c] = m_deb[c];
                e_pe[c]  = m_deb[c] & ~m_debq[c];
                e_ne[c]  = ~m_deb[c] & m_debq[c];
                if (e_pe[c]) begin
                    m_act[c]   = 1'b1;
                    m_start[c] = cyc;
                end
                d = cyc - m_start[c];
                e_lp[c] = m_act[c] && !e_ne[c] && (d == HOLD);
`ifdef BUTTON_REPEAT_EN
                e_rp[c] = m_act[c] && !e_ne[c] && (d > HOLD) && ((d - HOLD) % REP == 0);
`else
                e_rp[c] = 1'b0;
`endif
                if (e_ne[c]) m_act[c] = 1'b0;
            end
        end
    endtask

    function automatic logic [6*CH-1:0] dut_vec();
        return {debounced, p_edge, n_edge, any_edge, long_press, rpt};
    endfunction

    task automatic check_vec(input string name, input logic [6*CH-1:0] act, input logic [6*CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d actual=%h required=%h", name, sn, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic clear_trk();
        for (int c = 0; c < CH; c++) begin
            t_p[c] = -1; t_n[c] = -1; t_lp[c] = -1;
            n_pe[c] = 0; n_ne[c] = 0; n_lp[c] = 0; n_rp[c] = 0; late[c] = 0;
        end
        rep1_t.delete();
    endtask

    // One clock: drive at the falling edge, advance the model at the rising
    // edge, compare at the next falling edge.
    task automatic step(input logic [CH-1:0] v, input logic rst);
        noisy = v;
        reset = rst;
        @(posedge clk);
        model_step(v, rst);
        @(negedge clk);
        sn++;
        check_vec("model", dut_vec(), {e_deb, e_pe, e_ne, e_pe | e_ne, e_lp, e_rp});
        for (int c = 0; c < CH; c++) begin
            if (t_n[c] >= 0 && (long_press[c] || rpt[c])) late[c]++;
            if (p_edge[c]) begin n_pe[c]++; if (t_p[c] < 0) t_p[c] = sn; end
            if (n_edge[c]) begin n_ne[c]++; if (t_n[c] < 0) t_n[c] = sn; end
            if (long_press[c]) begin n_lp[c]++; if (t_lp[c] < 0) t_lp[c] = sn; end
            if (rpt[c]) n_rp[c]++;
        end
        if (rpt[1]) rep1_t.push_back(sn);
    endtask

    task automatic hold(input logic [CH-1:0] v, input int n);
        for (int k = 0; k < n; k++) step(v, 1'b0);
    endtask

    initial begin
        logic [CH-1:0] lvl;
        int            dur [CH];
        int            base;

        reset = 1'b1;
        noisy = '0;
        clear_trk();
        @(negedge clk);

        // Clean press on ch0: reset row, input high for 8 cycles, then low.
        for (int k = 0; k < 20; k++) begin
            tbl[k].rst   = (k == 0);
            tbl[k].noisy = (k >= 1 && k <= 8) ? 2'b01 : 2'b00;
            tbl[k].deb   = (k >= 6 && k <= 13) ? 2'b01 : 2'b00;
            tbl[k].pe    = (k == 6) ? 2'b01 : 2'b00;
            tbl[k].ne    = (k == 14) ? 2'b01 : 2'b00;
            tbl[k].lp    = 2'b00;
            tbl[k].rp    = 2'b00;
        end
        for (int k = 0; k < 20; k++) begin
            step(tbl[k].noisy, tbl[k].rst);
            check_vec("table", dut_vec(),
                      {tbl[k].deb, tbl[k].pe, tbl[k].ne, tbl[k].pe | tbl[k].ne, tbl[k].lp, tbl[k].rp});
        end

        // Bounce on ch0: toggle every 2 cycles for 20 cycles, then stay high.
        hold(2'b00, 4);
        clear_trk();
        for (int k = 0; k < 20; k++) step(((k / 2) % 2 == 0) ? 2'b01 : 2'b00, 1'b0);
        check_int("bounce_quiet", n_pe[0] + n_ne[0], 0);
        base = sn + 1;
        hold(2'b01, 8);
        check_int("bounce_p_offset", t_p[0] - base, 5);
        check_int("bounce_p_count", n_pe[0], 1);
        hold(2'b00, 10);

        // Long press on ch1 held 25 cycles.
        clear_trk();
        hold(2'b10, 25);
        hold(2'b00, 12);
        check_int("long_offset", t_lp[1] - t_p[1], HOLD);
        check_int("long_count", n_lp[1], 1);
        check_int("ch0_silent", n_pe[0] + n_ne[0] + n_lp[0] + n_rp[0], 0);
        check_int("late_pulses", late[1], 0);
`ifdef BUTTON_REPEAT_EN
        check_int("rep_count_min3", (rep1_t.size() >= 3) ? 1 : 0, 1);
        if (rep1_t.size() >= 3) begin
            check_int("rep1_offset", rep1_t[0] - t_lp[1], REP);
            check_int("rep2_offset", rep1_t[1] - t_lp[1], 2 * REP);
            check_int("rep3_offset", rep1_t[2] - t_lp[1], 3 * REP);
        end
`else
        check_int("rep_count_zero", n_rp[1], 0);
`endif

        // Release landing exactly on the long-press cycle.
        clear_trk();
        hold(2'b01, 10);
        hold(2'b00, 12);
        check_int("rel_on_hold_n", t_n[0] - t_p[0], HOLD);
        check_int("rel_on_hold_long", n_lp[0], 0);

        // Reset while ch0 is held past long_press, input still high.
        clear_trk();
        hold(2'b01, 17);
        check_int("pre_reset_long", n_lp[0], 1);
        step(2'b01, 1'b1);
        check_vec("reset_clear", dut_vec(), '0);
        base = sn;
        clear_trk();
        hold(2'b01, 10);
        check_int("reset_refire", t_p[0] - base, 6);
        hold(2'b00, 10);

        // Randomised levels: glitches and long holds, occasional reset.
        lvl = '0;
        for (int c = 0; c < CH; c++) dur[c] = 1;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < CH; c++) begin
                dur[c]--;
                if (dur[c] <= 0) begin
                    lvl[c] = ~lvl[c];
                    dur[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5))
                                                         : int'($urandom_range(4, 40));
                end
            end
            step(lvl, ($urandom_range(0, 499) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
